// File: rtl/poly1305_verify.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : poly1305_verify
// Description : Sequencer that feeds a message, block by block, to an external
//               Poly1305 core, then compares the core's final tag against a
//               received tag in constant time.
//               - Pads short blocks (byte n = 0x01, remainder zero).
//               - Bounds each core transaction with a TIMEOUT-cycle watchdog.
//               - Treats an empty message as tag = s.
// Ports       : clk, rst_i             clock, synchronous active-high reset
//               start, key_r, key_s    begin message, one-time key halves
//               in_valid/in_ready/in_data/in_bytes/in_last, tag_in
//                                      message beat stream and received tag
//               core_r/core_s/core_m/core_fb/core_ld/core_first
//                                      block request to the Poly1305 core
//               core_p, core_rdy       core result
//               busy, done, tag_ok, err
//                                      status
// Revision    : 1.0 - initial release
// ============================================================================
module poly1305_verify #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         start,
    input  logic [127:0] key_r,
    input  logic [127:0] key_s,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [4:0]   in_bytes,
    input  logic         in_last,
    input  logic [127:0] tag_in,
    output logic [127:0] core_r,
    output logic [127:0] core_s,
    output logic [127:0] core_m,
    output logic         core_fb,
    output logic         core_ld,
    output logic         core_first,
    input  logic [127:0] core_p,
    input  logic         core_rdy,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic         err
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        ISSUE     = 3'd2,
        WAIT_CORE = 3'd3,
        COMPARE   = 3'd4,
        FIN       = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [127:0]         key_r_q, key_r_d;
    logic [127:0]         key_s_q, key_s_d;
    logic                 first_q, first_d;     // next block is the message's first
    logic                 last_q, last_d;       // block in flight carries in_last
    logic                 pend_q, pend_d;       // zero-byte last beat: tag select step
    logic [127:0]         m_q, m_d;
    logic                 fb_q, fb_d;
    logic                 cfirst_q, cfirst_d;
    logic [127:0]         tag_q, tag_d;
    logic [127:0]         tagin_q, tagin_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 ok_q, ok_d;
    logic                 err_q, err_d;

    // Keep the low n bytes, place the 0x01 terminator at byte n, zero the rest.
    // For n = 16 the block passes through unchanged.
    function automatic logic [127:0] pad_block(input logic [127:0] d, input logic [4:0] n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < n) begin
                r[8*k +: 8] = d[8*k +: 8];
            end else if (5'(k) == n) begin
                r[8*k +: 8] = 8'h01;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= IDLE;
            key_r_q  <= '0;
            key_s_q  <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            pend_q   <= 1'b0;
            m_q      <= '0;
            fb_q     <= 1'b0;
            cfirst_q <= 1'b0;
            tag_q    <= '0;
            tagin_q  <= '0;
            cnt_q    <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_r_q  <= key_r_d;
            key_s_q  <= key_s_d;
            first_q  <= first_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            m_q      <= m_d;
            fb_q     <= fb_d;
            cfirst_q <= cfirst_d;
            tag_q    <= tag_d;
            tagin_q  <= tagin_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_r_d  = key_r_q;
        key_s_d  = key_s_q;
        first_d  = first_q;
        last_d   = last_q;
        pend_d   = pend_q;
        m_d      = m_q;
        fb_d     = fb_q;
        cfirst_d = cfirst_q;
        tag_d    = tag_q;
        tagin_d  = tagin_q;
        cnt_d    = cnt_q;
        ok_d     = ok_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_r_d = key_r;
                    key_s_d = key_s;
                    first_d = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (in_valid) begin
                    if ((in_bytes > 5'd16) || ((in_bytes == 5'd0) && !in_last)) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end else begin
                        last_d = in_last;
                        if (in_last) begin
                            tagin_d = tag_in;
                        end
                        if (in_bytes == 5'd0) begin
                            // No block to issue; the tag source is chosen in
                            // the first COMPARE cycle.
                            pend_d  = 1'b1;
                            state_d = COMPARE;
                        end else begin
                            m_d      = pad_block(in_data, in_bytes);
                            fb_d     = (in_bytes == 5'd16);
                            cfirst_d = first_q;
                            state_d  = ISSUE;
                        end
                    end
                end
            end

            ISSUE: begin
                // The ISSUE cycle itself counts toward the watchdog.
                cnt_d   = c_cnt_one;
                state_d = WAIT_CORE;
            end

            WAIT_CORE: begin
                if (core_rdy) begin
                    tag_d   = core_p;
                    first_d = 1'b0;
                    state_d = last_q ? COMPARE : WAIT_DATA;
                end else if (cnt_q >= c_cnt_last) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            COMPARE: begin
                if (pend_q) begin
                    // Empty message: the tag is s alone.
                    pend_d = 1'b0;
                    if (first_q) begin
                        tag_d = key_s_q;
                    end
                end else begin
                    // Full-width reduction, no data-dependent early exit.
                    ok_d    = ~|(tag_q ^ tagin_q);
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == WAIT_DATA);
    assign core_ld    = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign core_r     = key_r_q;
    assign core_s     = key_s_q;
    assign core_m     = m_q;
    assign core_fb    = fb_q;
    assign core_first = cfirst_q;
    assign tag_ok     = ok_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_poly1305_verify.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_poly1305_verify
// Description : Self-checking bench for poly1305_verify. Single-beat messages
//               come from a vector table; RFC 8439 message, timeout and
//               reset-abort scenarios are hand-written sequences. A behavioural
//               core answers each core_ld after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly1305_verify;

    localparam int TO = 20;
    localparam logic [127:0] KR      = 128'ha806d542fe52447f336d555778bed685;
    localparam logic [127:0] KS      = 128'h1bf54941aff6bf4afdb20dfb8a800301;
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [271:0] MSG     = "Cryptographic Forum Research Group";

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_r = '0;
    logic [127:0] key_s = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [4:0]   in_bytes = '0;
    logic         in_last = 1'b0;
    logic [127:0] tag_in = '0;
    logic [127:0] core_r, core_s, core_m;
    logic         core_fb, core_ld, core_first;
    logic [127:0] core_p;
    logic         core_rdy;
    logic         busy, done, tag_ok, err;

    poly1305_verify #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst_i), .start(start), .key_r(key_r), .key_s(key_s),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bytes(in_bytes), .in_last(in_last), .tag_in(tag_in),
        .core_r(core_r), .core_s(core_s), .core_m(core_m), .core_fb(core_fb),
        .core_ld(core_ld), .core_first(core_first), .core_p(core_p),
        .core_rdy(core_rdy), .busy(busy), .done(done), .tag_ok(tag_ok), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural core ----------------
    bit           core_en = 1'b1;
    int           nld = 0;
    int           base = 0;
    int           ld_cyc = 0;
    int           rdy_cyc = 0;
    logic [127:0] ld_m [64];
    logic         ld_fb [64];
    logic         ld_first [64];
    logic [127:0] resp [4];

    initial begin : core_model
        int cnt;
        bit pend;
        logic [127:0] nxt;
        core_rdy = 1'b0;
        core_p   = '0;
        pend     = 1'b0;
        cnt      = 0;
        nxt      = '0;
        forever begin
            @(posedge clk);
            #1;
            core_rdy = 1'b0;
            if (core_ld) begin
                ld_m[nld % 64]     = core_m;
                ld_fb[nld % 64]    = core_fb;
                ld_first[nld % 64] = core_first;
                ld_cyc = cyc;
                nxt    = resp[(nld - base) & 3];
                nld++;
                pend = 1'b1;
                cnt  = 3;
            end else if (pend) begin
                if (!core_en) begin
                    pend = 1'b0;
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        core_rdy = 1'b1;
                        core_p   = nxt;
                        rdy_cyc  = cyc;
                        pend     = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        key_r = KR;
        key_s = KS;
        base  = nld;
        step();
        start = 1'b0;
        key_r = ~KR;
        key_s = '0;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic [4:0] nb, input logic last,
                             input logic [127:0] t, output int bcyc);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            step();
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        tag_in   = t;
        bcyc     = cyc;
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_bytes = 5'd0;
        in_last  = 1'b0;
        tag_in   = ~t;
    endtask

    task automatic wait_done(output int dcyc);
        int n;
        n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_wait: got 0 expected 1");
        end
        dcyc = cyc;
    endtask

    task automatic post_done(input string tn, input logic exp_ok, input logic exp_err);
        chk({tn, "_tag_ok"}, 128'(tag_ok), 128'(exp_ok));
        chk({tn, "_err"}, 128'(err), 128'(exp_err));
        chk({tn, "_key_r"}, core_r, KR);
        chk({tn, "_key_s"}, core_s, KS);
        step();
        chk({tn, "_done_pulse_busy"}, {126'd0, done, busy}, 128'd0);
        chk({tn, "_hold"}, {126'd0, tag_ok, err}, {126'd0, exp_ok, exp_err});
    endtask

    task automatic chk_zero(input string tn);
        chk({tn, "_flags"}, {120'd0, busy, done, tag_ok, err, core_ld, core_first, core_fb, in_ready}, 128'd0);
        chk({tn, "_core_m"}, core_m, 128'd0);
        chk({tn, "_core_r"}, core_r, 128'd0);
        chk({tn, "_core_s"}, core_s, 128'd0);
    endtask

    function automatic logic [127:0] rfc_beat(input int b);
        logic [127:0] d;
        logic [271:0] mv;
        int nb;
        mv = MSG;
        d  = {4{32'hA5A5A5A5}};
        nb = (b < 2) ? 16 : 2;
        for (int k = 0; k < nb; k++) begin
            d[8*k +: 8] = mv[(271 - 8*(16*b + k)) -: 8];
        end
        return d;
    endfunction

    task automatic run_rfc(input string tn, input logic [127:0] t, input logic exp_ok);
        int c0, bc, dc;
        logic [127:0] d [3];
        resp[0] = {4{32'h11111111}};
        resp[1] = {4{32'h22222222}};
        resp[2] = RFC_TAG;
        do_start();
        c0 = nld;
        for (int b = 0; b < 3; b++) begin
            d[b] = rfc_beat(b);
            send_beat(d[b], (b < 2) ? 5'd16 : 5'd2, (b == 2), t, bc);
        end
        wait_done(dc);
        chk({tn, "_ld_count"}, 128'(nld - c0), 128'd3);
        chk({tn, "_first"}, {125'd0, ld_first[c0 % 64], ld_first[(c0+1) % 64], ld_first[(c0+2) % 64]}, 128'b100);
        chk({tn, "_fb"}, {125'd0, ld_fb[c0 % 64], ld_fb[(c0+1) % 64], ld_fb[(c0+2) % 64]}, 128'b110);
        chk({tn, "_m0"}, ld_m[c0 % 64], d[0]);
        chk({tn, "_m1"}, ld_m[(c0+1) % 64], d[1]);
        chk({tn, "_m2"}, ld_m[(c0+2) % 64], 128'h0000_0000_0000_0000_0000_0000_0001_7075);
        chk({tn, "_latency"}, 128'(dc - rdy_cyc), 128'd2);
        post_done(tn, exp_ok, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]   nb;
        logic         last;
        logic [127:0] data;
        logic [127:0] tagin;
        logic [127:0] corep;
        logic         exp_ld;
        logic [127:0] exp_m;
        logic         exp_fb;
        logic         exp_ok;
        logic         exp_err;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int c0, bc, dc;
        tbl[0] = '{nb:5'd16, last:1'b1, data:128'h0f0e0d0c0b0a09080706050403020100,
                   tagin:128'h0123456789abcdef0011223344556677, corep:128'h0123456789abcdef0011223344556677,
                   exp_ld:1'b1, exp_m:128'h0f0e0d0c0b0a09080706050403020100, exp_fb:1'b1, exp_ok:1'b1, exp_err:1'b0};
        tbl[1] = '{nb:5'd1, last:1'b1, data:128'hffffffffffffffffffffffffffffffaa,
                   tagin:128'h80000000000000000000000000000000, corep:128'h0,
                   exp_ld:1'b1, exp_m:128'h000000000000000000000000000001aa, exp_fb:1'b0, exp_ok:1'b0, exp_err:1'b0};
        tbl[2] = '{nb:5'd15, last:1'b1, data:128'heeeeeeeeeeeeeeeeeeeeeeeeeeeeeeee,
                   tagin:128'hffffffffffffffffffffffffffffffff, corep:128'hffffffffffffffffffffffffffffffff,
                   exp_ld:1'b1, exp_m:128'h01eeeeeeeeeeeeeeeeeeeeeeeeeeeeee, exp_fb:1'b0, exp_ok:1'b1, exp_err:1'b0};
        tbl[3] = '{nb:5'd5, last:1'b1, data:128'h112233445566778899aabbccddeeff00,
                   tagin:128'h1, corep:128'h1,
                   exp_ld:1'b1, exp_m:128'h0000_0000_0000_0000_0000_01cc_ddee_ff00, exp_fb:1'b0, exp_ok:1'b1, exp_err:1'b0};
        tbl[4] = '{nb:5'd17, last:1'b1, data:128'h5, tagin:128'h0, corep:128'h0,
                   exp_ld:1'b0, exp_m:128'h0, exp_fb:1'b0, exp_ok:1'b0, exp_err:1'b1};
        tbl[5] = '{nb:5'd0, last:1'b0, data:128'h5, tagin:128'h0, corep:128'h0,
                   exp_ld:1'b0, exp_m:128'h0, exp_fb:1'b0, exp_ok:1'b0, exp_err:1'b1};
        tbl[6] = '{nb:5'd0, last:1'b1, data:128'h5, tagin:KS, corep:128'h0,
                   exp_ld:1'b0, exp_m:128'h0, exp_fb:1'b0, exp_ok:1'b1, exp_err:1'b0};
        tbl[7] = '{nb:5'd31, last:1'b0, data:128'h5, tagin:128'h0, corep:128'h0,
                   exp_ld:1'b0, exp_m:128'h0, exp_fb:1'b0, exp_ok:1'b0, exp_err:1'b1};

        // Reset state
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        chk_zero("reset");

        // Single-beat vectors
        for (int i = 0; i < 8; i++) begin
            resp[0] = tbl[i].corep;
            do_start();
            c0 = nld;
            send_beat(tbl[i].data, tbl[i].nb, tbl[i].last, tbl[i].tagin, bc);
            wait_done(dc);
            chk($sformatf("v%0d_ld_count", i), 128'(nld - c0), 128'(tbl[i].exp_ld));
            if (tbl[i].exp_ld) begin
                chk($sformatf("v%0d_core_m", i), ld_m[c0 % 64], tbl[i].exp_m);
                chk($sformatf("v%0d_fb_first", i), {126'd0, ld_fb[c0 % 64], ld_first[c0 % 64]},
                    {126'd0, tbl[i].exp_fb, 1'b1});
                chk($sformatf("v%0d_latency", i), 128'(dc - rdy_cyc), 128'd2);
            end
            if (tbl[i].nb == 5'd0 && tbl[i].last) begin
                chk($sformatf("v%0d_empty_latency", i), 128'(dc - bc), 128'd3);
            end
            post_done($sformatf("v%0d", i), tbl[i].exp_ok, tbl[i].exp_err);
        end

        // RFC 8439 message, correct and corrupted tag
        run_rfc("rfc_good", RFC_TAG, 1'b1);
        run_rfc("rfc_bad", RFC_TAG ^ 128'h1, 1'b0);

        // Core never answers: watchdog fires TO cycles after core_ld
        core_en = 1'b0;
        do_start();
        send_beat(rfc_beat(0), 5'd16, 1'b1, RFC_TAG, bc);
        wait_done(dc);
        chk("timeout_latency", 128'(dc - ld_cyc), 128'(TO));
        post_done("timeout", 1'b0, 1'b1);
        core_en = 1'b1;

        // Reset while a block is in flight; the late core_rdy must be ignored
        resp[0] = RFC_TAG;
        do_start();
        send_beat(rfc_beat(0), 5'd16, 1'b0, RFC_TAG, bc);
        begin
            int n;
            n = 0;
            while (!core_ld && n < 100) begin
                step();
                n++;
            end
            checks++;
            if (!core_ld) begin
                errors++;
                $display("FAIL abort_ld_wait: got 0 expected 1");
            end
        end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk_zero("abort_rst");
        repeat (5) step();
        chk_zero("abort_after_rdy");
        run_rfc("rfc_after_abort", RFC_TAG, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
